// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops bytes from a synchronous FIFO read port and packs
// LANES consecutive bytes into one wide word on a valid/ready interface.
// A flush request emits the partial word with a per-lane keep mask.
// Pops are spaced IDLE/READ/CAPT so the FIFO's registered empty flag has
// settled before the next pop decision is taken.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  input  logic [WIDTH-1:0]         fifo_data,
  output logic                     fifo_rd_en,
  input  logic                     flush,
  output logic [WIDTH*LANES-1:0]   out_data,
  output logic [LANES-1:0]         out_keep,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  lanes [LANES];
  logic [LANES-1:0]  partial_keep;

  // Mask of lanes already filled, used when a flush emits a partial word.
  always_comb begin
    partial_keep = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      partial_keep[i] = (CW'(i) < count);
    end
  end

  // Next-state decision; flush outranks reading, inputs are ignored in OUT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (flush && (count != {CW{1'b0}})) begin
          state_next = OUT;
        end else if (!fifo_empty) begin
          state_next = READ;
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        state_next = CAPT;
      end
      CAPT: begin
        if (count == LAST_LANE) begin
          state_next = OUT;
        end else begin
          state_next = IDLE;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = OUT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fifo_rd_en <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_next;
      fifo_rd_en <= (state_next == READ);
      out_valid  <= (state_next == OUT);
    end
  end

  // Lane capture, fill counter and keep mask; cleared after each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= {CW{1'b0}};
      out_keep <= {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) begin
        lanes[i] <= {WIDTH{1'b0}};
      end
    end else begin
      case (state)
        IDLE: begin
          if (state_next == OUT) begin
            out_keep <= partial_keep;
          end
        end
        CAPT: begin
          lanes[count] <= fifo_data;
          if (count == LAST_LANE) begin
            count    <= {CW{1'b0}};
            out_keep <= {LANES{1'b1}};
          end else begin
            count <= count + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        OUT: begin
          if (out_ready) begin
            count    <= {CW{1'b0}};
            out_keep <= {LANES{1'b0}};
            for (int i = 0; i < LANES; i++) begin
              lanes[i] <= {WIDTH{1'b0}};
            end
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  // Flatten lane registers into the output word, lane 0 in the low bits.
  always_comb begin
    out_data = {(WIDTH*LANES){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      out_data[i*WIDTH +: WIDTH] = lanes[i];
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: FIFO model, byte-stream reference model
// feeding a scoreboard queue, and an independent output monitor.
module tb_fifo_rd_packer;

  localparam int WIDTH = 8;
  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic        hold_empty = 1'b0;
  int          ready_mode = 1;

  logic [7:0]  fq[$];
  logic [7:0]  pending[$];
  logic [35:0] exp_q[$];

  int tests = 0;
  int errors = 0;
  int pop_cnt = 0;
  int hs_cnt = 0;
  int valid_cycles = 0;

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_rst = 1'b1;
  logic        prev_rd = 1'b0;
  logic        prev_empty = 1'b1;
  logic [31:0] prev_data = 32'h0;
  logic [3:0]  prev_keep = 4'h0;
  logic [35:0] mon_word;

  fifo_rd_packer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .out_data(out_data),
    .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Synchronous FIFO model: data the cycle after rd_en, registered empty flag.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      pop_cnt++;
      tests++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL fifo_underflow: rd_en with %0d entries, expected >0", fq.size());
      end else begin
        fifo_data <= fq.pop_front();
      end
    end
    fifo_empty <= (fq.size() == 0) || hold_empty;
  end

  // Consumer ready driver.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: scoreboard compare on handshake, protocol checks.
  always @(negedge clk) begin
    if (out_valid) valid_cycles++;
    if (fifo_rd_en) begin
      check("pop_while_empty", {63'h0, prev_empty}, 64'h0);
      check("rd_en_single_pulse", {63'h0, prev_rd}, 64'h0);
    end
    if (prev_valid && !prev_ready && !prev_rst) begin
      check("hold_valid", {63'h0, out_valid}, 64'h1);
      check("hold_data", {32'h0, out_data}, {32'h0, prev_data});
      check("hold_keep", {60'h0, out_keep}, {60'h0, prev_keep});
    end
    if (out_valid && out_ready && !rst) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_word: got %0h keep %0h, expected none", out_data, out_keep);
      end else begin
        mon_word = exp_q.pop_front();
        check("word_data", {32'h0, out_data}, {32'h0, mon_word[31:0]});
        check("word_keep", {60'h0, out_keep}, {60'h0, mon_word[35:32]});
      end
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_rst   = rst;
    prev_rd    = fifo_rd_en;
    prev_empty = fifo_empty;
    prev_data  = out_data;
    prev_keep  = out_keep;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: emit whatever bytes are pending as one word.
  task automatic emit();
    logic [35:0] w;
    w = 36'h0;
    for (int i = 0; i < pending.size(); i++) begin
      w[i*8 +: 8] = pending[i];
      w[32+i] = 1'b1;
    end
    exp_q.push_back(w);
    pending.delete();
  endtask

  task automatic feed(input logic [7:0] b);
    fq.push_back(b);
    pending.push_back(b);
    if (pending.size() == LANES) emit();
  endtask

  task automatic model_flush();
    if (pending.size() > 0) emit();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || (fq.size() != 0)) && (n < budget)) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size() + fq.size()), 64'h0);
  endtask

  task automatic wait_fifo_idle(input string name);
    int n;
    n = 0;
    while ((fq.size() != 0) && (n < 200)) begin
      tick();
      n++;
    end
    check(name, 64'(fq.size()), 64'h0);
    repeat (4) tick();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, {63'h0, fifo_rd_en}, 64'h0);
    check({tag, "_valid"}, {63'h0, out_valid}, 64'h0);
    check({tag, "_data"}, {32'h0, out_data}, 64'h0);
    check({tag, "_keep"}, {60'h0, out_keep}, 64'h0);
  endtask

  int p0, v0, h0, n;

  initial begin
    // Reset with data waiting in the FIFO: nothing may be popped.
    ready_mode = 1;
    rst = 1'b1;
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
    repeat (3) tick();
    check_reset_outputs("reset");
    check("reset_no_pops", 64'(pop_cnt), 64'h0);

    // Full word.
    rst = 1'b0;
    p0 = pop_cnt; v0 = valid_cycles; h0 = hs_cnt;
    wait_drain("full_drain", 200);
    repeat (3) tick();
    check("full_pops", 64'(pop_cnt - p0), 64'd4);
    check("full_valid_cycles", 64'(valid_cycles - v0), 64'd1);
    check("full_handshakes", 64'(hs_cnt - h0), 64'd1);

    // Backpressure: word held, no pops until accepted.
    ready_mode = 0;
    feed(8'h55); feed(8'h66); feed(8'h77); feed(8'h88);
    feed(8'h99); feed(8'hA1); feed(8'hA2); feed(8'hA3);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check("bp_valid_seen", {63'h0, out_valid}, 64'h1);
    p0 = pop_cnt; h0 = hs_cnt;
    repeat (10) tick();
    check("bp_no_pops", 64'(pop_cnt - p0), 64'h0);
    check("bp_still_valid", {63'h0, out_valid}, 64'h1);
    check("bp_data_held", {32'h0, out_data}, 64'h88776655);
    ready_mode = 1;
    wait_drain("bp_drain", 200);
    check("bp_pops_resumed", 64'(pop_cnt - p0), 64'd4);
    check("bp_handshakes", 64'(hs_cnt - h0), 64'd2);

    // Flush of a partial word, then flush with nothing pending.
    h0 = hs_cnt;
    feed(8'hAA); feed(8'hBB);
    wait_fifo_idle("flush_pop_wait");
    check("flush_no_early_word", 64'(hs_cnt - h0), 64'h0);
    pulse_flush();
    model_flush();
    wait_drain("flush_drain", 50);
    check("flush_one_word", 64'(hs_cnt - h0), 64'd1);
    h0 = hs_cnt;
    pulse_flush();
    repeat (6) tick();
    check("flush_empty_ignored", 64'(hs_cnt - h0), 64'h0);

    // Empty throttle: empty toggles every 2 cycles over 12 bytes.
    h0 = hs_cnt;
    for (int i = 0; i < 12; i++) feed(8'(i * 17 + 3));
    n = 0;
    while (((fq.size() != 0) || (exp_q.size() != 0)) && n < 400) begin
      hold_empty = (((n / 2) % 2) == 0);
      tick();
      n++;
    end
    hold_empty = 1'b0;
    check("throttle_drain", 64'(fq.size() + exp_q.size()), 64'h0);
    check("throttle_words", 64'(hs_cnt - h0), 64'd3);

    // Reset mid-word drops the partial bytes.
    feed(8'hEE); feed(8'hFF);
    wait_fifo_idle("midrst_pop_wait");
    rst = 1'b1;
    pending.delete();
    repeat (2) tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    h0 = hs_cnt;
    feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
    wait_drain("midrst_drain", 200);
    check("midrst_words", 64'(hs_cnt - h0), 64'd1);

    // Randomized bursts, empty holds and backpressure, then final flush.
    ready_mode = 2;
    for (int it = 0; it < 60; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) feed(8'($urandom_range(0, 255)));
      hold_empty = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 6)) tick();
    end
    hold_empty = 1'b0;
    ready_mode = 1;
    wait_drain("rand_drain", 3000);
    repeat (4) tick();
    pulse_flush();
    model_flush();
    wait_drain("rand_flush_drain", 50);

    repeat (4) tick();
    check("final_scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
